alu_unit_mc: RTL

ALU_UNIT_MC -- requirements
Module: alu_unit_mc

---
 rtl/alu_unit_mc.sv | 95 +++++++++
 1 files changed

// File: rtl/alu_unit_mc.sv
// alu_unit_mc: multi-cycle integer ALU with an optional iterative shifter and a held writeback result
// Ports: clk; rst (asynchronous, active-low); issue_valid/issue_ready handshake carrying
// issue_op, issue_id, issue_a, issue_b, issue_const; wb_done/wb_ack handshake presenting
// wb_id and wb_rd; busy is high while an iterative shift is in progress.
module alu_unit_mc #(
  parameter int XLEN       = 32,
  parameter int ID_W       = 3,
  parameter int FAST_SHIFT = 1,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      issue_op,
  input  logic [ID_W-1:0] issue_id,
  input  logic [XLEN-1:0] issue_a,
  input  logic [XLEN-1:0] issue_b,
  input  logic [XLEN-1:0] issue_const,
  output logic            wb_done,
  input  logic            wb_ack,
  output logic [ID_W-1:0] wb_id,
  output logic [XLEN-1:0] wb_rd,
  output logic            busy
);
  localparam int SW = XLEN == 64 ? 6 : 5;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state;
  logic [SW-1:0]   shamt, rem, step;
  logic [XLEN-1:0] alu_res, sh_val, sh_next, sra_val;
  logic [1:0]      sh_dir;
  logic [ID_W-1:0] sh_id;
  logic            xfer, go_iter;
  assign busy        = state == SHIFT;
  assign issue_ready = state == IDLE && (!wb_done || wb_ack);
  assign xfer        = issue_valid && issue_ready;
  assign shamt       = issue_b[SW-1:0];
  // a zero-distance shift has nothing to iterate, so it completes like any single-cycle op
  assign go_iter     = FAST_SHIFT == 0 && issue_op >= 4'd7 && issue_op <= 4'd9 && shamt != '0;
  always_comb begin
    case (issue_op)
      4'd0:    alu_res = issue_a + issue_b;
      4'd1:    alu_res = issue_a - issue_b;
      4'd2:    alu_res = XLEN'($signed(issue_a) < $signed(issue_b));
      4'd3:    alu_res = XLEN'(issue_a < issue_b);
      4'd4:    alu_res = issue_a ^ issue_b;
      4'd5:    alu_res = issue_a | issue_b;
      4'd6:    alu_res = issue_a & issue_b;
      4'd7:    alu_res = issue_a << shamt;
      4'd8:    alu_res = issue_a >> shamt;
      4'd9:    alu_res = $signed(issue_a) >>> shamt;
      default: alu_res = issue_const;
    endcase
  end
  // each iteration moves by at most SHIFT_STEP; the final partial step takes the remainder
  assign step    = rem < SW'(SHIFT_STEP) ? rem : SW'(SHIFT_STEP);
  assign sra_val = $signed(sh_val) >>> step;
  assign sh_next = sh_dir == 2'd0 ? sh_val << step : sh_dir == 2'd1 ? sh_val >> step : sra_val;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wb_done <= 1'b0;
      wb_rd   <= '0;
      wb_id   <= '0;
      rem     <= '0;
      sh_val  <= '0;
      sh_dir  <= '0;
      sh_id   <= '0;
    end else if (state == IDLE) begin
      if (xfer && go_iter) begin
        state   <= SHIFT;
        wb_done <= 1'b0;
        sh_val  <= issue_a;
        rem     <= shamt;
        sh_dir  <= 2'(issue_op - 4'd7);
        sh_id   <= issue_id;
      end else if (xfer) begin
        wb_done <= 1'b1;
        wb_rd   <= alu_res;
        wb_id   <= issue_id;
      end else if (wb_ack) begin
        wb_done <= 1'b0;
      end
    end else begin
      sh_val <= sh_next;
      rem    <= rem - step;
      if (rem == step) begin
        state   <= IDLE;
        wb_done <= 1'b1;
        wb_rd   <= sh_next;
        wb_id   <= sh_id;
      end
    end
  end
endmodule
